prio_arbiter_param: RTL

//  Parametrised, registered successor to the 4-input priority encoder.
//  - Arbitrates N request lines: fixed priority (highest index wins) or round-robin.
//  - Holds the winning grant until the requester acknowledges it.
//  - Code output keeps the encoder convention: index+1, 0 = no request.
//  - Sits between request sources and a shared resource in the RT-level combinational/arbitration group.

---
 rtl/prio_arbiter_param.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/prio_arbiter_param.sv
// N-input registered arbiter (fixed priority or round-robin) that holds each grant until ack.
// Optional grant watchdog enabled by defining PRIO_ARB_TIMEOUT_EN.
module prio_arbiter_param #(
  parameter int N          = 8,
  parameter int TMO_CYCLES = 16,
  localparam int CW        = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          rr_mode,
  input  logic          ack,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] code,
  output logic          valid,
  output logic          timeout
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);
  localparam logic [N-1:0]  ONE_HOT0 = {{(N - 1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [CW-1:0] code_q, code_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          rr_q, rr_d;

  logic          win_found_s;
  logic [PW-1:0] win_idx_s;
  logic [PW-1:0] cand_s;
  logic          tmo_hit_s;

  // Descending search for the winner; fixed mode starts at N-1, round-robin at ptr with wrap.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < N; i++) begin
      if (rr_mode) begin
        cand_s = (int'(ptr_q) >= i) ? PW'(int'(ptr_q) - i) : PW'(int'(ptr_q) + N - i);
      end else begin
        cand_s = PW'(N - 1 - i);
      end
      win_idx_s   = (!win_found_s && req[cand_s]) ? cand_s : win_idx_s;
      win_found_s = win_found_s | req[cand_s];
    end
  end

`ifdef PRIO_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);

  logic [TW-1:0] wd_cnt_q, wd_cnt_d;

  assign tmo_hit_s = (state_q == ST_GRANT) && (wd_cnt_q == TW'(TMO_CYCLES - 1));

  // Watchdog counts un-acked GRANT cycles; held at zero outside GRANT so each grant starts fresh.
  always_comb begin
    if ((state_q == ST_GRANT) && !ack && !tmo_hit_s) begin
      wd_cnt_d = wd_cnt_q + TW'(1);
    end else begin
      wd_cnt_d = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, hold in GRANT until ack or watchdog release.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    code_d    = code_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    rr_d      = rr_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_GRANT;
          grant_d = ONE_HOT0 << win_idx_s;
          code_d  = CW'(win_idx_s) + CW'(1);
          valid_d = 1'b1;
          rr_d    = rr_mode;
        end else begin
          grant_d = '0;
          code_d  = '0;
          valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (ack || tmo_hit_s) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          code_d    = '0;
          valid_d   = 1'b0;
          timeout_d = tmo_hit_s & ~ack;
          // Last round-robin winner drops to lowest priority: ptr = w-1 with w = code-1.
          if (rr_q) begin
            ptr_d = (code_q == CW'(1)) ? PTR_LAST : PW'(code_q - CW'(2));
          end else begin
            ptr_d = ptr_q;
          end
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        code_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= PTR_LAST;
      rr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      rr_q      <= rr_d;
    end
  end

  assign grant   = grant_q;
  assign code    = code_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule
